mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer and arbiter directly upstream of the memory system wrapper. It accepts instruction-fetch requests from the PC stage and load/store requests from the datapath. It range- and alignment-checks each request against the text segment (0x0040_0000) and data segment (0x1001_0000), then drives the wrapper's write-enable, select, address and write-data lines for exactly one access cycle. It returns read data or a store acknowledge with a one-cycle valid pulse. One request is in flight at a time; fetch and data ports are arbitrated round-robin.

## Interface
- DATA_WIDTH, 32, word width of memory data
- MEMORY_DEPTH, 64, words per segment; legal span = 4*MEMORY_DEPTH bytes from base
- TEXT_BASE, 32'h0040_0000, byte base of instruction segment
- DATA_BASE, 32'h1001_0000, byte base of data segment

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request
- if_addr_i  in  32  fetch byte address
- if_ready_o  out  1  fetch accepted this cycle
- if_valid_o  out  1  fetch response pulse
- if_instr_o  out  DATA_WIDTH  fetched instruction
- if_err_o  out  1  fetch fault, qualified by if_valid_o
- dm_req_i  in  1  data request
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  32  data byte address
- dm_wdata_i  in  DATA_WIDTH  store data
- dm_ready_o  out  1  data request accepted this cycle
- dm_valid_o  out  1  data response pulse
- dm_rdata_o  out  DATA_WIDTH  load data
- dm_err_o  out  1  data fault, qualified by dm_valid_o
- mem_we_o  out  1  to wrapper write enable
- mem_sel_o  out  1  to wrapper select: 1 = data memory, 0 = instruction memory
- mem_addr_o  out  32  to wrapper full byte address
- mem_wdata_o  out  DATA_WIDTH  to wrapper write data
- mem_rdata_i  in  DATA_WIDTH  from wrapper read data, combinational from mem_addr_o/mem_sel_o

## Operation
FSM states are IDLE, ACCESS, RESP and ERR.

**IDLE**
- Grant when at least one request is high.
- If both requests are high, grant the port not granted last; after reset, data wins.
- Assert the granted port's ready combinationally for that cycle only.
- On the edge, capture the request into internal registers (port, we, addr, wdata), update last_grant, and run the checks:
  - offset = addr − base as a 32-bit unsigned subtraction.
  - Fetch base is TEXT_BASE; data base is DATA_BASE.
  - Legal iff offset < 4*MEMORY_DEPTH and addr[1:0] == 0.
  - Fetches are always reads.
- Legal request → ACCESS. Illegal request → ERR.

**ACCESS** (one cycle)
- mem_sel_o = 1 for data, 0 for fetch.
- mem_addr_o = captured addr; mem_wdata_o = captured wdata.
- mem_we_o = captured we, data port only.
- On the edge, register mem_rdata_i into the port's data output (loads and fetches only) → RESP.

**RESP** (one cycle)
- Assert the owning port's valid with err = 0 → IDLE.
- Store response is an acknowledge only; dm_rdata_o keeps its previous value.

**ERR** (one cycle)
- Owning port's valid = 1, err = 1.
- No memory cycle is issued: mem_we_o stays 0 and the data output is unchanged.
- → IDLE.

**General rules**
- Ready outputs are 0 outside IDLE.
- Requests not granted stay pending; requesters hold req and operands until ready.

## Timing
- Reset values:
  - FSM = IDLE, last_grant = fetch (so data wins first), all ready/valid/err = 0.
  - mem_we_o = 0, mem_sel_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - if_instr_o = 0, dm_rdata_o = 0.
- Legal request: accept edge T; ACCESS during T+1; valid high during T+2. Next accept no earlier than T+3, giving 3 cycles per access.
- Illegal request: valid + err during T+1; next accept at T+2.
- mem_we_o is high for exactly one cycle per legal store and never otherwise.
- mem_* outputs hold their last values outside ACCESS; only mem_we_o returns to 0.
- Simultaneous requests: strict alternation. Continuous requests on both ports give data, fetch, data, …
- Asynchronous reset mid-ACCESS drops mem_we_o immediately; the aborted request produces no response.
- Boundaries:
  - Offset 4*MEMORY_DEPTH−4 is legal.
  - Offset 4*MEMORY_DEPTH is an error.
  - Address below base wraps to a large offset → error.

## Test plan
- Store 0xFFFFFFFF to 0x10010000, then load 0x10010000:
  - Store: mem_we_o=1 and mem_sel_o=1 for one cycle; dm_valid_o at T+2 with err=0.
  - Load: dm_rdata_o=0xFFFFFFFF at its T+2.
- Fetch 0x00400000, 0x00400004, …, 0x0040001C: eight if_valid_o pulses, 3 cycles apart, with mem_sel_o=0 and mem_we_o=0 throughout.
- dm_req_i and if_req_i held high together for 12 cycles: grants alternate data, fetch, data, fetch; no starvation.
- Load 0x10010002, store 0x00400000, load 0x10010100 (MEMORY_DEPTH=64): each gives dm_valid_o=1, dm_err_o=1 one cycle after accept, with no mem_we_o pulse. Load 0x100100FC succeeds.
- rst asserted during ACCESS of a store to 0x10010008: mem_we_o drops asynchronously, no valid pulse, all outputs at reset values; a later load of 0x10010008 returns the pre-store contents.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-wrapper bus of mem_access_ctrl.
// The master side (PC stage, datapath, wrapper) drives requests; the slave side is the controller.
interface mem_access_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [31:0]           if_addr_i;
    logic                  if_ready_o;
    logic                  if_valid_o;
    logic [DATA_WIDTH-1:0] if_instr_o;
    logic                  if_err_o;

    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [31:0]           dm_addr_i;
    logic [DATA_WIDTH-1:0] dm_wdata_i;
    logic                  dm_ready_o;
    logic                  dm_valid_o;
    logic [DATA_WIDTH-1:0] dm_rdata_o;
    logic                  dm_err_o;

    logic                  mem_we_o;
    logic                  mem_sel_o;
    logic [31:0]           mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i,
        input  if_ready_o, if_valid_o, if_instr_o, if_err_o,
        input  dm_ready_o, dm_valid_o, dm_rdata_o, dm_err_o,
        input  mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i,
        output if_ready_o, if_valid_o, if_instr_o, if_err_o,
        output dm_ready_o, dm_valid_o, dm_rdata_o, dm_err_o,
        output mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin fetch/data arbiter that range-checks each request and issues one
// single-cycle memory access, returning a one-cycle valid (with err) to the owner.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter logic [31:0] TEXT_BASE    = 32'h0040_0000,
    parameter logic [31:0] DATA_BASE    = 32'h1001_0000
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    localparam logic [31:0] SPAN = 32'(4 * MEMORY_DEPTH);

    state_t      state;
    logic        last_fetch;
    logic        cap_data;
    logic        cap_we;
    logic        grant_data;
    logic        grant_fetch;
    logic [31:0] req_addr;
    logic [31:0] req_off;
    logic        req_legal;

    // Wrapping subtraction turns below-base addresses into huge offsets, so one compare covers both sides.
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (state == IDLE) begin
            grant_data  = bus.dm_req_i && (!bus.if_req_i || last_fetch);
            grant_fetch = bus.if_req_i && !grant_data;
        end
        req_addr  = grant_data ? bus.dm_addr_i : bus.if_addr_i;
        req_off   = req_addr - (grant_data ? DATA_BASE : TEXT_BASE);
        req_legal = (req_off < SPAN) && (req_addr[1:0] == 2'b00);
    end

    assign bus.dm_ready_o = grant_data;
    assign bus.if_ready_o = grant_fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_fetch      <= 1'b1;
            cap_data        <= 1'b0;
            cap_we          <= 1'b0;
            bus.if_valid_o  <= 1'b0;
            bus.if_err_o    <= 1'b0;
            bus.if_instr_o  <= '0;
            bus.dm_valid_o  <= 1'b0;
            bus.dm_err_o    <= 1'b0;
            bus.dm_rdata_o  <= '0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_sel_o   <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
        end else begin
            bus.if_valid_o <= 1'b0;
            bus.if_err_o   <= 1'b0;
            bus.dm_valid_o <= 1'b0;
            bus.dm_err_o   <= 1'b0;
            bus.mem_we_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_data || grant_fetch) begin
                        cap_data   <= grant_data;
                        cap_we     <= grant_data && bus.dm_we_i;
                        last_fetch <= grant_fetch;
                        if (req_legal) begin
                            // mem_* only move on a legal access; an error leaves them holding.
                            state           <= ACCESS;
                            bus.mem_we_o    <= grant_data && bus.dm_we_i;
                            bus.mem_sel_o   <= grant_data;
                            bus.mem_addr_o  <= req_addr;
                            bus.mem_wdata_o <= grant_data ? bus.dm_wdata_i : '0;
                        end else begin
                            state <= ERR;
                            if (grant_data) begin
                                bus.dm_valid_o <= 1'b1;
                                bus.dm_err_o   <= 1'b1;
                            end else begin
                                bus.if_valid_o <= 1'b1;
                                bus.if_err_o   <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (cap_data) begin
                        if (!cap_we) bus.dm_rdata_o <= bus.mem_rdata_i;
                        bus.dm_valid_o <= 1'b1;
                    end else begin
                        bus.if_instr_o <= bus.mem_rdata_i;
                        bus.if_valid_o <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: wrapper memory model, reference model of segments
// and response registers, directed table, multi-cycle sequences and random traffic.
module tb_mem_access_ctrl;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;
    localparam int unsigned DEPTH     = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cycle = 0;
    int          checks = 0;
    int          errors = 0;

    mem_access_ctrl_if #(.DATA_WIDTH(32)) bus ();

    mem_access_ctrl #(
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(DEPTH),
        .TEXT_BASE   (TEXT_BASE),
        .DATA_BASE   (DATA_BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] init_word(input bit seg, input logic [5:0] i);
        return seg ? 32'hD000_0000 + {26'b0, i} * 32'h0001_0003
                   : 32'h1C00_0000 + {26'b0, i} * 32'h0000_0105;
    endfunction

    // Memory wrapper: instruction segment is a fixed pattern, data segment is writable.
    logic [31:0] dmem [DEPTH];
    logic [31:0] rd_off;
    bit          mem_loaded;

    always_comb begin
        rd_off          = bus.mem_addr_o - (bus.mem_sel_o ? DATA_BASE : TEXT_BASE);
        bus.mem_rdata_i = bus.mem_sel_o ? dmem[rd_off[7:2]] : init_word(1'b0, rd_off[7:2]);
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= init_word(1'b1, 6'(i));
            mem_loaded <= 1'b1;
        end else if (bus.mem_we_o && bus.mem_sel_o) begin
            dmem[rd_off[7:2]] <= bus.mem_wdata_o;
        end
    end

    int unsigned we_cycles = 0;
    int unsigned we_bad    = 0;
    always @(negedge clk) begin
        if (bus.mem_we_o) we_cycles++;
        if (bus.mem_we_o && !bus.mem_sel_o) we_bad++;
    end

    // Reference model state
    logic [31:0] ref_dmem [DEPTH];
    logic [31:0] model_dm_rdata;
    logic [31:0] model_if_instr;
    int unsigned exp_we = 0;
    int unsigned last_valid_cyc = 0;

    function automatic bit model_err(input bit is_data, input logic [31:0] addr);
        longint a, b;
        a = longint'(addr);
        b = longint'(is_data ? DATA_BASE : TEXT_BASE);
        return !(a >= b && a < b + 4 * longint'(DEPTH) && (a % 4) == 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_dm_rdata = '0;
        model_if_instr = '0;
    endtask

    task automatic xact(input bit is_data, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_err, input string tag);
        bit          got;
        logic        v, e, ov;
        logic [31:0] d, exp_rd, off;
        off    = addr - (is_data ? DATA_BASE : TEXT_BASE);
        exp_rd = is_data ? ref_dmem[off[7:2]] : init_word(1'b0, off[7:2]);
        @(posedge clk);
        #1;
        if (is_data) begin
            bus.dm_req_i = 1'b1; bus.dm_we_i = we; bus.dm_addr_i = addr; bus.dm_wdata_i = wdata;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = addr;
        end
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            got = is_data ? bus.dm_ready_o : bus.if_ready_o;
        end
        check({tag, " accept"}, 64'(got), 64'(1));
        @(posedge clk);
        #1;
        bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0; bus.dm_we_i = 1'b0;
        if (!got) return;
        @(negedge clk);
        v  = is_data ? bus.dm_valid_o : bus.if_valid_o;
        e  = is_data ? bus.dm_err_o   : bus.if_err_o;
        d  = is_data ? bus.dm_rdata_o : bus.if_instr_o;
        ov = is_data ? bus.if_valid_o : bus.dm_valid_o;
        if (exp_err) begin
            check({tag, " err valid"}, 64'(v), 64'(1));
            check({tag, " err flag"}, 64'(e), 64'(1));
            check({tag, " err no we"}, 64'(bus.mem_we_o), 64'(0));
            check({tag, " err data held"}, 64'(d), 64'(is_data ? model_dm_rdata : model_if_instr));
            check({tag, " err other valid"}, 64'(ov), 64'(0));
            last_valid_cyc = cycle;
            return;
        end
        check({tag, " access no valid"}, 64'(v), 64'(0));
        check({tag, " access sel"}, 64'(bus.mem_sel_o), 64'(is_data));
        check({tag, " access addr"}, 64'(bus.mem_addr_o), 64'(addr));
        check({tag, " access we"}, 64'(bus.mem_we_o), 64'(is_data && we));
        if (is_data && we) check({tag, " access wdata"}, 64'(bus.mem_wdata_o), 64'(wdata));
        @(negedge clk);
        v  = is_data ? bus.dm_valid_o : bus.if_valid_o;
        e  = is_data ? bus.dm_err_o   : bus.if_err_o;
        d  = is_data ? bus.dm_rdata_o : bus.if_instr_o;
        ov = is_data ? bus.if_valid_o : bus.dm_valid_o;
        check({tag, " resp valid"}, 64'(v), 64'(1));
        check({tag, " resp err"}, 64'(e), 64'(0));
        check({tag, " resp other valid"}, 64'(ov), 64'(0));
        check({tag, " resp we low"}, 64'(bus.mem_we_o), 64'(0));
        if (is_data && we) begin
            check({tag, " store rdata held"}, 64'(d), 64'(model_dm_rdata));
            ref_dmem[off[7:2]] = wdata;
            exp_we++;
        end else begin
            if (is_data) model_dm_rdata = exp_rd;
            else model_if_instr = exp_rd;
            check({tag, " resp data"}, 64'(d), 64'(exp_rd));
        end
        last_valid_cyc = cycle;
    endtask

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    function automatic vec_t mk(input bit is_data, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit exp_err, input bit chk_rd,
                                input logic [31:0] exp_rd, input string name);
        vec_t v;
        v.is_data = is_data; v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_err = exp_err; v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.name = name;
        return v;
    endfunction

    vec_t        vecs [14];
    int unsigned grant_cyc [4];
    bit          grant_dat [4];

    initial begin
        vecs[0]  = mk(1, 1, 32'h1001_0000, 32'hFFFF_FFFF, 0, 0, 32'h0,          "st_base");
        vecs[1]  = mk(1, 0, 32'h1001_0000, 32'h0,         0, 1, 32'hFFFF_FFFF, "ld_base");
        vecs[2]  = mk(1, 0, 32'h1001_0002, 32'h0,         1, 0, 32'h0,          "ld_misalign");
        vecs[3]  = mk(1, 1, 32'h0040_0000, 32'h5555_AAAA, 1, 0, 32'h0,          "st_textseg");
        vecs[4]  = mk(1, 0, 32'h1001_0100, 32'h0,         1, 0, 32'h0,          "ld_past_end");
        vecs[5]  = mk(1, 0, 32'h1001_00FC, 32'h0,         0, 1, 32'hD03F_00BD, "ld_last");
        vecs[6]  = mk(0, 0, 32'h0040_0000, 32'h0,         0, 1, 32'h1C00_0000, "if_base");
        vecs[7]  = mk(0, 0, 32'h0040_0100, 32'h0,         1, 0, 32'h0,          "if_past_end");
        vecs[8]  = mk(0, 0, 32'h003F_FFFC, 32'h0,         1, 0, 32'h0,          "if_below");
        vecs[9]  = mk(0, 0, 32'h0040_00FE, 32'h0,         1, 0, 32'h0,          "if_misalign");
        vecs[10] = mk(1, 1, 32'h1001_00FC, 32'h1234_5678, 0, 0, 32'h0,          "st_last");
        vecs[11] = mk(1, 0, 32'h1001_00FC, 32'h0,         0, 1, 32'h1234_5678, "ld_last2");
        vecs[12] = mk(1, 0, 32'h1000_FFFC, 32'h0,         1, 0, 32'h0,          "ld_below");
        vecs[13] = mk(0, 0, 32'h0040_00FC, 32'h0,         0, 1, 32'h1C00_403B, "if_last");

        for (int i = 0; i < DEPTH; i++) ref_dmem[i] = init_word(1'b1, 6'(i));
        model_dm_rdata = '0;
        model_if_instr = '0;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst if_valid", 64'(bus.if_valid_o), 64'(0));
        check("rst dm_valid", 64'(bus.dm_valid_o), 64'(0));
        check("rst errs", 64'({bus.if_err_o, bus.dm_err_o}), 64'(0));
        check("rst mem_we", 64'(bus.mem_we_o), 64'(0));
        check("rst mem_sel", 64'(bus.mem_sel_o), 64'(0));
        check("rst mem_addr", 64'(bus.mem_addr_o), 64'(0));
        check("rst mem_wdata", 64'(bus.mem_wdata_o), 64'(0));
        check("rst if_instr", 64'(bus.if_instr_o), 64'(0));
        check("rst dm_rdata", 64'(bus.dm_rdata_o), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xact(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].name);
            if (vecs[i].chk_rd)
                check({vecs[i].name, " table data"},
                      64'(vecs[i].is_data ? bus.dm_rdata_o : bus.if_instr_o), 64'(vecs[i].exp_rd));
        end

        // Eight back-to-back fetches, three cycles apart, no write enable
        begin
            int unsigned prev, w0;
            prev = 0;
            w0   = we_cycles;
            for (int i = 0; i < 8; i++) begin
                xact(1'b0, 1'b0, TEXT_BASE + 32'(4 * i), 32'h0, 1'b0, "fetch_seq");
                if (i > 0) check("fetch_seq spacing", 64'(last_valid_cyc - prev), 64'(3));
                prev = last_valid_cyc;
            end
            check("fetch_seq no we", 64'(we_cycles), 64'(w0));
        end

        // Both ports held high: grants must alternate data, fetch, data, fetch
        begin
            int          ng, both;
            bit          dr, fr;
            logic [31:0] fa, da;
            do_reset();
            ng = 0; both = 0;
            fa = TEXT_BASE; da = DATA_BASE;
            bus.if_req_i = 1'b1; bus.if_addr_i = fa;
            bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = da;
            for (int c = 0; c < 40 && ng < 4; c++) begin
                @(negedge clk);
                dr = bus.dm_ready_o;
                fr = bus.if_ready_o;
                if (dr && fr) both++;
                if (dr || fr) begin
                    grant_dat[ng] = dr;
                    grant_cyc[ng] = cycle;
                    ng++;
                end
                @(posedge clk);
                #1;
                if (dr) begin da = da + 4; bus.dm_addr_i = da; end
                if (fr) begin fa = fa + 4; bus.if_addr_i = fa; end
            end
            bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0;
            repeat (4) @(posedge clk);
            check("arb grant count", 64'(ng), 64'(4));
            check("arb both ready", 64'(both), 64'(0));
            for (int i = 0; i < ng; i++) begin
                check("arb order", 64'(grant_dat[i]), 64'(i % 2 == 0));
                if (i > 0) check("arb spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(3));
            end
        end

        // Asynchronous reset during the ACCESS cycle of a store
        begin
            bit got;
            int vcount;
            @(posedge clk);
            #1;
            bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1;
            bus.dm_addr_i = 32'h1001_0008; bus.dm_wdata_i = 32'hDEAD_BEEF;
            got = 1'b0;
            for (int n = 0; n < 8 && !got; n++) begin
                @(negedge clk);
                got = bus.dm_ready_o;
            end
            check("rstmid accept", 64'(got), 64'(1));
            @(posedge clk);
            #1;
            bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0;
            check("rstmid we before", 64'(bus.mem_we_o), 64'(1));
            #2 rst = 1'b1;
            #1;
            check("rstmid we dropped", 64'(bus.mem_we_o), 64'(0));
            check("rstmid mem_sel", 64'(bus.mem_sel_o), 64'(0));
            check("rstmid mem_addr", 64'(bus.mem_addr_o), 64'(0));
            check("rstmid mem_wdata", 64'(bus.mem_wdata_o), 64'(0));
            check("rstmid valids", 64'({bus.dm_valid_o, bus.if_valid_o}), 64'(0));
            check("rstmid data outs", 64'({bus.dm_rdata_o, bus.if_instr_o}), 64'(0));
            @(posedge clk);
            #1 rst = 1'b0;
            model_dm_rdata = '0;
            model_if_instr = '0;
            vcount = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (bus.dm_valid_o || bus.if_valid_o) vcount++;
            end
            check("rstmid no response", 64'(vcount), 64'(0));
            xact(1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b0, "rstmid reload");
            check("rstmid old contents", 64'(bus.dm_rdata_o), 64'(32'hD002_0006));
        end

        // Random traffic against the reference model
        for (int r = 0; r < 60; r++) begin
            bit          isd, w;
            int unsigned kind;
            logic [31:0] base, a;
            isd  = 1'($urandom_range(0, 1));
            w    = isd && 1'($urandom_range(0, 1));
            base = isd ? DATA_BASE : TEXT_BASE;
            kind = $urandom_range(0, 9);
            if (kind <= 6)      a = base + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (kind == 7) a = base + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (kind == 8) a = base + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
            else                a = base - 32'(4 * $urandom_range(1, 100));
            xact(isd, w, a, $urandom, model_err(isd, a), "rand");
        end

        repeat (3) @(posedge clk);
        check("total we cycles", 64'(we_cycles), 64'(exp_we));
        check("we without data sel", 64'(we_bad), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
